pipe_muxn: RTL and testbench

PIPE_MUXN -- requirements
Module: pipe_muxn

---
 rtl/pipe_muxn_if.sv | 28 ++
 rtl/pipe_muxn.sv | 123 ++++++++++++
 tb/tb_pipe_muxn.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_muxn_if.sv
// Handshake bundle for pipe_muxn: upstream lanes/select, flush, and the registered output side.
interface pipe_muxn_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );

    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/pipe_muxn.sv
// N-lane select mux feeding a 2-entry skid buffer; in_ready is a flop, independent of out_ready.
module pipe_muxn #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_muxn_if.slave        io
);
    localparam int SEL_W   = $clog2(NUM_IN);
    localparam int N_SLOTS = 2 ** SEL_W;
    localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
    logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;

    // Lane table padded to a power of two so any select value indexes in bounds.
    logic [WIDTH-1:0] lanes [N_SLOTS];
    logic [WIDTH-1:0] new_data;
    logic             new_err;
    logic             out_valid;
    logic             in_fire, out_fire;

    always_comb begin
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            lanes[k] = '0;
        end
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            lanes[k] = io.in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        new_err  = ({1'b0, io.in_sel} >= NUM_IN_W);
        new_data = new_err ? '0 : lanes[io.in_sel];
    end

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = io.in_valid && in_ready_q;
    assign out_fire  = out_valid && io.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = new_data;
                    main_sel_d  = io.in_sel;
                    main_err_d  = new_err;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = new_data;
                    main_sel_d  = io.in_sel;
                    main_err_d  = new_err;
                end else if (in_fire) begin
                    state_d     = FULL;
                    skid_data_d = new_data;
                    skid_sel_d  = io.in_sel;
                    skid_err_d  = new_err;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    main_err_d  = skid_err_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (io.flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid;
    assign io.out_data  = main_data_q;
    assign io.out_sel   = main_sel_q;
    assign io.out_err   = main_err_q;
endmodule

// File: tb/tb_pipe_muxn.sv
// Directed checks of pipe_muxn (4-lane and 3-lane builds) plus a short random run against a queue model.
module tb_pipe_muxn;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_muxn_if #(.WIDTH(8), .NUM_IN(4)) a_if ();
    pipe_muxn_if #(.WIDTH(8), .NUM_IN(3)) b_if ();

    pipe_muxn #(.WIDTH(8), .NUM_IN(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .io(a_if));
    pipe_muxn #(.WIDTH(8), .NUM_IN(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .io(b_if));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; outputs are sampled and new inputs driven 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic v, input logic r, input logic [7:0] d,
                           input logic [1:0] s);
        check({tag, ".valid"}, a_if.out_valid, v);
        check({tag, ".ready"}, a_if.in_ready, r);
        if (v) begin
            check({tag, ".data"}, a_if.out_data, d);
            check({tag, ".sel"},  a_if.out_sel, s);
            check({tag, ".err"},  a_if.out_err, 1'b0);
        end
    endtask

    logic [8:0] q [$];
    logic [7:0] exp_lane;
    logic       m_valid, m_ready;

    initial begin
        rst_n        = 1'b0;
        a_if.in_data = 32'h4433_2211;
        a_if.in_sel  = '0;
        a_if.in_valid = 1'b0;
        a_if.flush   = 1'b0;
        a_if.out_ready = 1'b1;
        b_if.in_data = 24'hCC_BB_AA;
        b_if.in_sel  = '0;
        b_if.in_valid = 1'b0;
        b_if.flush   = 1'b0;
        b_if.out_ready = 1'b1;

        repeat (3) step();
        check("rst.valid", a_if.out_valid, 1'b0);
        check("rst.ready", a_if.in_ready, 1'b1);
        check("rst.data",  a_if.out_data, 8'h00);
        check("rst.b_ready", b_if.in_ready, 1'b1);
        rst_n = 1'b1;
        step();
        check("post_rst.ready", a_if.in_ready, 1'b1);

        // Streaming, no bubbles.
        a_if.in_valid = 1'b1;
        a_if.in_sel = 2'd0; step(); check_a("s0", 1'b1, 1'b1, 8'h11, 2'd0);
        a_if.in_sel = 2'd1; step(); check_a("s1", 1'b1, 1'b1, 8'h22, 2'd1);
        a_if.in_sel = 2'd2; step(); check_a("s2", 1'b1, 1'b1, 8'h33, 2'd2);
        a_if.in_sel = 2'd3; step(); check_a("s3", 1'b1, 1'b1, 8'h44, 2'd3);
        a_if.in_valid = 1'b0; step(); check_a("s_idle", 1'b0, 1'b1, 8'h00, 2'd0);

        // Backpressure: third offered entry is refused, main holds the first.
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_sel = 2'd0; step(); check_a("bp1", 1'b1, 1'b1, 8'h11, 2'd0);
        a_if.in_sel = 2'd1; step(); check_a("bp2", 1'b1, 1'b0, 8'h11, 2'd0);
        a_if.in_sel = 2'd2; step(); check_a("bp3", 1'b1, 1'b0, 8'h11, 2'd0);
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b1;
        step(); check_a("drain1", 1'b1, 1'b1, 8'h22, 2'd1);
        step(); check_a("drain2", 1'b0, 1'b1, 8'h00, 2'd0);

        // Flush from FULL with a simultaneous input offer.
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_sel = 2'd0; step();
        a_if.in_sel = 2'd1; step(); check_a("fl_full", 1'b1, 1'b0, 8'h11, 2'd0);
        a_if.flush = 1'b1;
        a_if.in_sel = 2'd3; step(); check_a("fl_now", 1'b0, 1'b1, 8'h00, 2'd0);
        a_if.flush = 1'b0;
        a_if.in_valid = 1'b0;
        a_if.out_ready = 1'b1;
        step(); check_a("fl_after", 1'b0, 1'b1, 8'h00, 2'd0);

        // Reset mid-operation from FULL.
        a_if.out_ready = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_sel = 2'd2; step();
        a_if.in_sel = 2'd3; step(); check_a("mr_full", 1'b1, 1'b0, 8'h33, 2'd2);
        a_if.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("mr.valid", a_if.out_valid, 1'b0);
        check("mr.ready", a_if.in_ready, 1'b1);
        check("mr.data",  a_if.out_data, 8'h00);
        check("mr.sel",   a_if.out_sel, 2'd0);
        check("mr.err",   a_if.out_err, 1'b0);
        rst_n = 1'b1;
        a_if.out_ready = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.in_sel = 2'd2; step(); check_a("mr_s2", 1'b1, 1'b1, 8'h33, 2'd2);
        a_if.in_sel = 2'd3; step(); check_a("mr_s3", 1'b1, 1'b1, 8'h44, 2'd3);
        a_if.in_valid = 1'b0; step(); check_a("mr_idle", 1'b0, 1'b1, 8'h00, 2'd0);

        // Out-of-range select on the 3-lane build.
        b_if.in_valid = 1'b1;
        b_if.in_sel = 2'd3; step();
        check("oor.valid", b_if.out_valid, 1'b1);
        check("oor.data",  b_if.out_data, 8'h00);
        check("oor.err",   b_if.out_err, 1'b1);
        check("oor.sel",   b_if.out_sel, 2'd3);
        b_if.in_sel = 2'd2; step();
        check("ok2.data", b_if.out_data, 8'hCC);
        check("ok2.err",  b_if.out_err, 1'b0);
        check("ok2.sel",  b_if.out_sel, 2'd2);
        b_if.in_sel = 2'd1; step();
        check("ok1.data", b_if.out_data, 8'hBB);
        check("ok1.err",  b_if.out_err, 1'b0);
        b_if.in_valid = 1'b0; step();
        check("b_idle.valid", b_if.out_valid, 1'b0);

        // Random valid/ready on the 4-lane build against an ordered queue of {err, data}.
        for (int i = 0; i < 300; i++) begin
            m_valid = (q.size() != 0);
            m_ready = (q.size() < 2);
            a_if.in_data   = $urandom;
            a_if.in_sel    = 2'($urandom_range(0, 3));
            a_if.in_valid  = 1'($urandom_range(0, 1));
            a_if.out_ready = 1'($urandom_range(0, 1));
            exp_lane = a_if.in_data[a_if.in_sel*8 +: 8];
            if (m_valid && a_if.out_ready) void'(q.pop_front());
            if (a_if.in_valid && m_ready) q.push_back({1'b0, exp_lane});
            step();
            check("rnd.valid", a_if.out_valid, (q.size() != 0));
            check("rnd.ready", a_if.in_ready, (q.size() < 2));
            if (q.size() != 0) begin
                check("rnd.data", a_if.out_data, q[0][7:0]);
                check("rnd.err",  a_if.out_err, q[0][8]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
